pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline. Drives the write enables of
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
//   - data-memory wait states (MEM stage);
//   - load-use hazards (ID vs EX);
//   - taken branches (ID).
//  Bounds memory waits with a timeout and counts stall cycles for performance debug.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive memory-stall cycles before error; legal range >= 2
//  CNT_W        32  width of stall_cycles performance counter
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst           in   1      synchronous, active-high reset
//  id_rs         in   5      rs field of instruction in ID
//  id_rt         in   5      rt field of instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt as a source
//  ex_rd         in   5      destination register of instruction in EX
//  ex_memread    in   1      EX instruction is a load
//  mem_memread   in   1      MemRead out of EX/MEM
//  mem_memwrite  in   1      MemWrite out of EX/MEM
//  dmem_ready    in   1      data memory completes access this cycle
//  branch_taken  in   1      ID resolved a taken branch/jump
//  dmem_req      out  1      data memory access request
//  pc_write      out  1      PC write enable
//  ifid_write    out  1      IF/ID write enable
//  ifid_flush    out  1      IF/ID loads a NOP
//  idex_write    out  1      ID/EX write enable
//  idex_bubble   out  1      ID/EX loads all-zero control (NOP)
//  exmem_write   out  1      EX/MEM write enable
//  memwb_bubble  out  1      MEM/WB loads all-zero control
//  mem_err       out  1      sticky memory-timeout error
//  stall_cycles  out  CNT_W  stall-cycle count, saturating
// BEHAVIOUR
//  - State machine RUN / MWAIT / ERR, registered; wait_cnt is $clog2(MEM_TIMEOUT+1) bits.
//  - All other outputs are combinational from state and inputs, with zero latency.
//  - Define: acc = mem_memread|mem_memwrite.
//  - Define: mstall = acc & ~dmem_ready & state!=ERR.
//  - Define: lu = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//  - Priority is reset > ERR > mstall > lu > branch_taken. Exactly one action per cycle.
//  - rst=1: every enable, bubble, flush and dmem_req is 0; mem_err=0.
//    At the edge: state<=RUN, wait_cnt<=0, stall_cycles<=0.
//  - ERR: all enables, bubbles, flushes and dmem_req are 0. mem_err=1.
//    ERR holds until rst.
//  - dmem_req = acc & state!=ERR. A request stays asserted while EX/MEM is frozen.
//  - mstall: pc/ifid/idex/exmem_write=0 and memwb_bubble=1. Upstream stages hold;
//    WB receives bubbles.
//  - lu (no mstall): pc_write=0, ifid_write=0, idex_bubble=1 (idex_write=1),
//    exmem_write=1. Exactly one bubble is inserted per load-use.
//  - branch_taken only (no lu, no mstall): all enables=1, ifid_flush=1.
//    A branch masked by a stall is not remembered. The held ID instruction re-presents it.
//  - Otherwise: all enables=1, bubbles and flushes=0.
//  - RUN: mstall -> MWAIT, wait_cnt<=1. Otherwise stay.
//  - MWAIT: dmem_ready -> RUN, wait_cnt<=0. That cycle is not a stall and the pipeline advances.
//    Else if wait_cnt==MEM_TIMEOUT-1 -> ERR. Else wait_cnt<=wait_cnt+1.
//    ERR is therefore entered at the edge ending the MEM_TIMEOUT-th consecutive stalled cycle.
//  - dmem_ready already high in the first cycle of acc: no stall, state stays RUN.
//  - Back-to-back accesses: each new access evaluates mstall afresh; wait_cnt restarts at 1.
//  - stall_cycles: +1 on every edge where pc_write==0 in RUN or MWAIT (not rst, not ERR).
//    Saturates at all-ones; never wraps.
//  - Reset mid-MWAIT: the request is abandoned. The memory side must tolerate dmem_req dropping.
// TESTING
//  1. ex_memread=1, ex_rd=5, id_rs=5, dmem_ready=1 -> one cycle pc_write=0, ifid_write=0,
//     idex_bubble=1, exmem_write=1; stall_cycles=1.
//  2. ex_memread=1, ex_rd=0, id_rs=0 -> no stall, all enables 1. ex_rd=7, id_rt=7,
//     id_uses_rt=0 -> no stall.
//  3. mem_memread=1, dmem_ready low 3 cycles then high -> 3 cycles all enables 0,
//     memwb_bubble=1, dmem_req=1; state RUN->MWAIT->RUN; stall_cycles +3.
//  4. MEM_TIMEOUT=4, mem_memwrite=1, dmem_ready never -> mem_err=1 after 4th edge.
//     All enables and dmem_req 0; ERR held 20 cycles until rst.
//  5. mstall, lu and branch_taken all together -> mstall action only: ifid_flush=0,
//     idex_bubble=0, memwb_bubble=1.
//  6. rst pulse while in MWAIT with wait_cnt=2 -> next cycle state RUN, wait_cnt=0,
//     stall_cycles=0, mem_err=0; CNT_W=4 counter saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: memory waits, load-use bubbles and
// branch flushes, with a bounded memory-wait timeout and a saturating stall counter.
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_mem_memread,
  input  logic             i_mem_memwrite,
  input  logic             i_dmem_ready,
  input  logic             i_branch_taken,
  output logic             o_dmem_req,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_write,
  output logic             o_idex_bubble,
  output logic             o_exmem_write,
  output logic             o_memwb_bubble,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMwait, StErr} state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_acc;
  logic w_err;
  logic w_mstall;
  logic w_lu;

  assign w_acc    = i_mem_memread | i_mem_memwrite;
  assign w_err    = (r_state == StErr);
  assign w_mstall = w_acc & ~i_dmem_ready & ~w_err;
  assign w_lu     = i_ex_memread & (i_ex_rd != 5'd0) &
                    ((i_ex_rd == i_id_rs) | (i_id_uses_rt & (i_ex_rd == i_id_rt)));

  assign o_dmem_req     = w_acc & ~w_err & ~i_rst;
  assign o_mem_err      = w_err & ~i_rst;
  assign o_stall_cycles = r_stall_cycles;

  // Exactly one action per cycle, in priority order.
  always_comb begin
    o_pc_write     = 1'b0;
    o_ifid_write   = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_write   = 1'b0;
    o_idex_bubble  = 1'b0;
    o_exmem_write  = 1'b0;
    o_memwb_bubble = 1'b0;
    if (i_rst || w_err) begin
      // everything held off
    end else if (w_mstall) begin
      o_memwb_bubble = 1'b1;
    end else if (w_lu) begin
      o_idex_write  = 1'b1;
      o_idex_bubble = 1'b1;
      o_exmem_write = 1'b1;
    end else begin
      o_pc_write    = 1'b1;
      o_ifid_write  = 1'b1;
      o_idex_write  = 1'b1;
      o_exmem_write = 1'b1;
      o_ifid_flush  = i_branch_taken;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StRun;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_mstall) begin
            r_state    <= StMwait;
            r_wait_cnt <= WaitW'(1);
          end
        end
        StMwait: begin
          if (i_dmem_ready) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WaitLast) begin
            r_state <= StErr;
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
          end
        end
        StErr: r_state <= StErr;
        default: r_state <= StErr;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (!w_err && !o_pc_write && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4) with an expected-value queue.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_memread, mem_memread, mem_memwrite, dmem_ready, branch_taken;
  logic       dmem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic       exmem_write, memwb_bubble, mem_err;
  logic [3:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_rd(ex_rd), .i_ex_memread(ex_memread), .i_mem_memread(mem_memread),
    .i_mem_memwrite(mem_memwrite), .i_dmem_ready(dmem_ready), .i_branch_taken(branch_taken),
    .o_dmem_req(dmem_req), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
    .o_ifid_flush(ifid_flush), .o_idex_write(idex_write), .o_idex_bubble(idex_bubble),
    .o_exmem_write(exmem_write), .o_memwb_bubble(memwb_bubble), .o_mem_err(mem_err),
    .o_stall_cycles(stall_cycles)
  );

  // {dmem_req, pc, ifid, flush, idex, idex_bubble, exmem, memwb_bubble, mem_err}
  localparam logic [8:0] Norm  = 9'b011010100;
  localparam logic [8:0] NormA = 9'b111010100;
  localparam logic [8:0] Lu    = 9'b000011100;
  localparam logic [8:0] LuA   = 9'b100011100;
  localparam logic [8:0] Br    = 9'b011110100;
  localparam logic [8:0] Mst   = 9'b100000010;
  localparam logic [8:0] ErrV  = 9'b000000001;
  localparam logic [8:0] RstV  = 9'b000000000;

  typedef struct packed {
    logic [8:0] ctrl;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_cnt   = 4'd0;

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] rd, input logic exmr, input logic mmr,
                      input logic mmw, input logic rdy, input logic br, input logic [8:0] exp);
    exp_t e;
    logic [8:0] got;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd; ex_memread = exmr;
    mem_memread = mmr; mem_memwrite = mmw; dmem_ready = rdy; branch_taken = br;
    sb.push_back('{ctrl: exp, cnt: m_cnt});
    // Counter model: count cycles with the PC held, outside reset and error.
    if (r) m_cnt = 4'd0;
    else if (!exp[7] && !exp[0] && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    @(negedge clk);
    e   = sb.pop_front();
    got = {dmem_req, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, memwb_bubble, mem_err};
    n_tests++;
    assert (got === e.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: got %b expected %b", tag, got, e.ctrl);
    end
    n_tests++;
    assert (stall_cycles === e.cnt) else begin
      n_fail++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0; ex_memread = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    //    tag          rst rs  rt urt rd exmr mmr mmw rdy br  exp
    step("reset",      1, 0,  0, 0, 0,  0,  0,  0,  0,  0, RstV);
    step("idle",       0, 0,  0, 0, 0,  0,  0,  0,  0,  0, Norm);
    step("lu_rs",      0, 5,  0, 0, 5,  1,  0,  0,  1,  0, Lu);
    step("after_lu",   0, 5,  0, 0, 0,  0,  0,  0,  1,  0, Norm);
    step("lu_r0",      0, 0,  0, 0, 0,  1,  0,  0,  0,  0, Norm);
    step("lu_rt_unused", 0, 3, 7, 0, 7, 1,  0,  0,  0,  0, Norm);
    step("lu_rt",      0, 3,  7, 1, 7,  1,  0,  0,  0,  0, Lu);
    step("branch",     0, 0,  0, 0, 0,  0,  0,  0,  0,  1, Br);
    step("rd_ready",   0, 0,  0, 0, 0,  0,  1,  0,  1,  0, NormA);
    for (int i = 0; i < 3; i++)
      step("mwait3",   0, 0,  0, 0, 0,  0,  1,  0,  0,  0, Mst);
    step("mwait_done", 0, 0,  0, 0, 0,  0,  1,  0,  1,  0, NormA);
    step("b2b_stall",  0, 0,  0, 0, 0,  0,  1,  0,  0,  0, Mst);
    step("ready_lu",   0, 9,  0, 0, 9,  1,  0,  1,  1,  0, LuA);
    step("all_three",  0, 9,  0, 0, 9,  1,  1,  0,  0,  1, Mst);
    step("mwait_cnt2", 0, 0,  0, 0, 0,  0,  1,  0,  0,  0, Mst);
    step("rst_mwait",  1, 0,  0, 0, 0,  0,  1,  0,  0,  0, RstV);
    step("post_rst",   0, 0,  0, 0, 0,  0,  0,  0,  0,  0, Norm);
    for (int i = 0; i < 4; i++)
      step("timeout",  0, 0,  0, 0, 0,  0,  0,  1,  0,  0, Mst);
    for (int i = 0; i < 20; i++)
      step("err_hold", 0, 4,  0, 0, 4,  1,  0,  1, 1'(i & 1), 1, ErrV);
    step("err_rst",    1, 0,  0, 0, 0,  0,  0,  1,  0,  0, RstV);
    step("err_clear",  0, 0,  0, 0, 0,  0,  0,  0,  0,  0, Norm);
    for (int i = 0; i < 17; i++)
      step("saturate", 0, 6,  0, 0, 6,  1,  0,  0,  0,  0, Lu);
    step("sat_hold",   0, 0,  0, 0, 0,  0,  0,  0,  0,  0, Norm);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
